// File: rtl/bist_top.sv
// Memory BIST: 16x8 RAM, a four-phase march sequencer (W0/R0/W1/R1) and a comparator.
// Optional build macro BIST_FAULT_INJECT_EN plants a stuck-at-0 on bit 0 of address 5.
module bist_top #(
  parameter int unsigned       ADDR_W = 4,
  parameter int unsigned       DATA_W = 8,
  parameter logic [DATA_W-1:0] PAT    = 8'h55
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic fail,
  output logic done
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_W0   = 3'd1;
  localparam logic [2:0] S_R0   = 3'd2;
  localparam logic [2:0] S_W1   = 3'd3;
  localparam logic [2:0] S_R1   = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              fail_q, fail_d;
  logic              done_q, done_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              we_c;
  logic              cmp_c;
  logic [DATA_W-1:0] wdata_c;
  logic [DATA_W-1:0] exp_c;
  logic [DATA_W-1:0] wdata_m_c;
  logic [DATA_W-1:0] rdata_c;

`ifdef BIST_FAULT_INJECT_EN
  // Bit 0 of address 5 is stuck at 0: masked on both write and read.
  localparam logic [ADDR_W-1:0] FAULT_ADDR = ADDR_W'(5);
  localparam logic [DATA_W-1:0] FAULT_MASK = ~DATA_W'(1);

  always_comb begin
    wdata_m_c = wdata_c;
    rdata_c   = mem_q[addr_q];
    if (addr_q == FAULT_ADDR) begin
      wdata_m_c = wdata_c & FAULT_MASK;
      rdata_c   = mem_q[addr_q] & FAULT_MASK;
    end
  end
`else
  always_comb begin
    wdata_m_c = wdata_c;
    rdata_c   = mem_q[addr_q];
  end
`endif

  // RAM: synchronous write, asynchronous read, no reset on contents.
  always_ff @(posedge clk) begin
    if (we_c) begin
      mem_q[addr_q] <= wdata_m_c;
    end
  end

  // Sequencer next-state and comparator.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    fail_d  = fail_q;
    done_d  = done_q;
    we_c    = 1'b0;
    cmp_c   = 1'b0;
    wdata_c = PAT;
    exp_c   = PAT;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_W0;
          addr_d  = '0;
          fail_d  = 1'b0;
          done_d  = 1'b0;
        end
      end
      S_W0: begin
        we_c    = 1'b1;
        wdata_c = PAT;
        addr_d  = addr_q + ADDR_W'(1);
        if (addr_q == ADDR_MAX) state_d = S_R0;
      end
      S_R0: begin
        cmp_c  = 1'b1;
        exp_c  = PAT;
        addr_d = addr_q + ADDR_W'(1);
        if (addr_q == ADDR_MAX) state_d = S_W1;
      end
      S_W1: begin
        we_c    = 1'b1;
        wdata_c = ~PAT;
        addr_d  = addr_q + ADDR_W'(1);
        if (addr_q == ADDR_MAX) state_d = S_R1;
      end
      S_R1: begin
        cmp_c  = 1'b1;
        exp_c  = ~PAT;
        addr_d = addr_q + ADDR_W'(1);
        if (addr_q == ADDR_MAX) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        addr_d  = '0;
      end
    endcase

    if (cmp_c && (rdata_c != exp_c)) fail_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      fail_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      fail_q  <= fail_d;
      done_q  <= done_d;
    end
  end

  assign fail = fail_q;
  assign done = done_q;

endmodule

// File: tb/tb_bist_top.sv
// Directed bench for bist_top: reset, full runs, restart, mid-run reset, start toggling.
// Expectations follow BIST_FAULT_INJECT_EN when it is defined for the build.
module tb_bist_top;

  logic clk;
  logic rst;
  logic start;
  logic fail;
  logic done;

  int n_vec;
  int n_err;

`ifdef BIST_FAULT_INJECT_EN
  localparam bit FI = 1'b1;
`else
  localparam bit FI = 1'b0;
`endif

  // R0 reaches address 5 in the cycle ending at edge E22.
  localparam int FAIL_EDGE = 22;
  localparam int DONE_EDGE = 64;

  bist_top dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .fail  (fail),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int k, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s @k=%0d: observed %b expected %b", tag, k, obs, exp);
    end
  endtask

  function automatic logic exp_fail(input int k);
    return FI && (k >= FAIL_EDGE);
  endfunction

  // Launch with E0 and check both outputs after every edge through E64.
  task automatic run_check(input string tag, input bit toggle);
    start = 1'b1;
    tick();
    check({tag, "_e0_done"}, 0, done, 1'b0);
    check({tag, "_e0_fail"}, 0, fail, 1'b0);
    for (int k = 1; k <= DONE_EDGE; k++) begin
      start = (toggle && k < 60) ? k[0] : 1'b0;
      tick();
      check({tag, "_done"}, k, done, logic'(k >= DONE_EDGE));
      check({tag, "_fail"}, k, fail, exp_fail(k));
    end
    start = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    start = 1'b0;

    tick();
    tick();
    check("rst_done", 0, done, 1'b0);
    check("rst_fail", 0, fail, 1'b0);

    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_done", i, done, 1'b0);
      check("idle_fail", i, fail, 1'b0);
    end

    run_check("run1", 1'b0);

    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_done", i, done, 1'b1);
      check("hold_fail", i, fail, FI);
    end

    run_check("restart", 1'b1);

    for (int i = 0; i < 2; i++) begin
      tick();
      check("hold2_done", i, done, 1'b1);
      check("hold2_fail", i, fail, FI);
    end

    // Mid-run reset at E30 (inside R0).
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k < 30; k++) begin
      tick();
    end
    check("pre_rst_fail", 29, fail, exp_fail(29));
    check("pre_rst_done", 29, done, 1'b0);
    rst = 1'b1;
    tick();
    check("midrst_done", 30, done, 1'b0);
    check("midrst_fail", 30, fail, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("postrst_done", i, done, 1'b0);
      check("postrst_fail", i, fail, 1'b0);
    end

    run_check("after_rst", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bist_top.md
# bist_top

Self-contained memory built-in self-test block: an internal 16×8 RAM, a march-style pattern sequencer and a comparator. A single `start` launches a four-phase write/read-compare sweep. The block reports `done` on completion and a sticky `fail` if any read mismatched. It sits at the top of the BIST hierarchy and is driven directly by a system clock, reset and start strobe.

## Interface
- `ADDR_W`, 4: RAM address width; depth = 2^ADDR_W.
- `DATA_W`, 8: RAM word width.
- `PAT`, 8'h55: background pattern; its bitwise inverse is the second pattern.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `start` input 1: level-sampled launch request.
- `fail` output 1: sticky mismatch flag for the current run.
- `done` output 1: run complete; held until restart or reset.

## Operation
- FSM states: IDLE, W0, R0, W1, R1, DONE. Address counter `addr` is ADDR_W bits.
- IDLE:
  - `start`=1 at an edge → W0, `addr`=0, `fail` cleared.
  - Otherwise stay in IDLE.
- W0: write `PAT` to `mem[addr]`.
  - `addr` increments each clock.
  - At `addr`=max the counter wraps to 0 and the FSM enters R0.
- R0: combinational read of `mem[addr]`, compared against `PAT`.
  - Mismatch sets `fail` at the same edge.
  - Wrap at max → W1.
- W1: write `~PAT`. Wrap at max → R1.
- R1: read and compare against `~PAT`. Wrap at max → DONE.
- DONE:
  - `done`=1 and `fail` holds its value.
  - `start`=1 → W0 with `addr`=0, and `fail` and `done` cleared.
  - Otherwise stay in DONE.
- The test never aborts early; a fail still runs to DONE.
- `start` is ignored in W0/R0/W1/R1.
- RAM:
  - Synchronous write, asynchronous read.
  - Only the sequencer accesses it.
  - Contents are not affected by `rst`.

## Timing
- Reset: state=IDLE, `addr`=0, `fail`=0, `done`=0.
- Reset mid-run aborts immediately at that edge with the same values.
- Edge numbering: E0 is the edge that samples `start`=1 in IDLE.
  - W0 occupies addr 0..15 after E0..E15.
  - R0 is entered at E16, W1 at E32, R1 at E48, DONE at E64.
  - `done` reads high after E64, i.e. 65 clocks from the start edge.
- Compare-to-`fail` latency: one edge. A mismatch while in state R0/R1 at address a sets `fail` at the edge that ends that cycle.
  - For R0 at address a, this is edge E(17+a).
  - For R1 at address a, this is edge E(49+a).
- Both outputs are registered; no combinational path from inputs to outputs.
- `start` held high across several edges:
  - Only the IDLE/DONE sample matters.
  - `start` still high when DONE is entered triggers an immediate restart.

## Configuration
- `BIST_FAULT_INJECT_EN`, when defined:
  - RAM bit 0 at address 5 is stuck at 0; writes to that bit are ignored and it reads 0.
  - `PAT`=8'h55 reads back 8'h54 there, so R0 detects the fault and `fail`=1 at DONE.
- When undefined: fault-free RAM; `fail` stays 0 for every run.

## Test plan
- Reset check: `rst`=1 for 2 clocks → `done`=0 and `fail`=0. Holding IDLE with `start`=0 for 10 clocks keeps both outputs at 0.
- Fault-free run, macro undefined:
  - Stimulus: single-cycle `start` after reset.
  - Response: `done` rises exactly after E64 and stays high; `fail`=0 throughout.
- Fault injection, `BIST_FAULT_INJECT_EN` defined:
  - Stimulus: the same run.
  - Response: `fail` rises after E22 (R0, addr 5); `done` rises after E64 with `fail`=1.
- Restart from DONE:
  - Stimulus: pulse `start` again with the macro defined.
  - Response: `fail` and `done` drop at the sampling edge. The new run repeats the same timing relative to the new E0.
- Mid-run reset:
  - Stimulus: assert `rst` at E30 (during R0).
  - Response: outputs 0, FSM in IDLE. A subsequent `start` gives a full 65-clock run to `done`.
- Start during run: toggling `start` during W0..R1 → no effect on the E64 completion time.
